mmu_driver: RTL and testbench

MMU_DRIVER -- requirements
Module: mmu_driver

---
 rtl/mmu_driver_pkg.sv | 21 ++
 rtl/mmu.sv | 68 ++++++
 rtl/mmu_driver.sv | 144 ++++++++++++++
 tb/tb_mmu_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mmu_driver_pkg.sv
// Shared constants and types for the MMU driver slice: state encodings,
// stream lengths, operand width and a byte-extraction helper.
package mmu_driver_pkg;

    localparam int BYTES_IN  = 8;
    localparam int BYTES_OUT = 4;
    localparam int OPW       = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } drv_state_t;

    // Return byte k (0 = least significant) of a 32-bit word.
    function automatic logic [OPW-1:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: OPW];
    endfunction

endpackage

// File: rtl/mmu.sv
// Small 2x2 matrix-multiply unit with 8-bit wrapping arithmetic.
// Operands are row-major, element (r,c) in byte 2r+c of each flat word.
// done pulses for one cycle after start has been seen high for
// START_CYCLES consecutive cycles; the product is valid alongside it.
module mmu
    import mmu_driver_pkg::*;
#(
    parameter int START_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A_flat,
    input  logic [31:0] B_flat,
    output logic [31:0] C_flat,
    output logic        done
);

    localparam int CW = $clog2(START_CYCLES + 1);
    localparam logic [CW-1:0] LAST_START = CW'(START_CYCLES - 1);

    logic [OPW-1:0] w_a00, w_a01, w_a10, w_a11;
    logic [OPW-1:0] w_b00, w_b01, w_b10, w_b11;
    logic [OPW-1:0] w_c00, w_c01, w_c10, w_c11;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_c;
    logic           r_done;

    assign w_a00 = A_flat[7:0];
    assign w_a01 = A_flat[15:8];
    assign w_a10 = A_flat[23:16];
    assign w_a11 = A_flat[31:24];
    assign w_b00 = B_flat[7:0];
    assign w_b01 = B_flat[15:8];
    assign w_b10 = B_flat[23:16];
    assign w_b11 = B_flat[31:24];

    // Products truncate to 8 bits: the result wraps modulo 256.
    assign w_c00 = w_a00 * w_b00 + w_a01 * w_b10;
    assign w_c01 = w_a00 * w_b01 + w_a01 * w_b11;
    assign w_c10 = w_a10 * w_b00 + w_a11 * w_b10;
    assign w_c11 = w_a10 * w_b01 + w_a11 * w_b11;

    // Count consecutive start cycles and publish the product on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_c    <= '0;
            r_done <= 1'b0;
        end else if (start) begin
            if (r_cnt == LAST_START) begin
                r_cnt  <= '0;
                r_c    <= {w_c11, w_c10, w_c01, w_c00};
                r_done <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_done <= 1'b0;
            end
        end else begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end
    end

    assign C_flat = r_c;
    assign done   = r_done;

endmodule

// File: rtl/mmu_driver.sv
// Byte-serial front end for the MMU. Collects eight operand bytes
// (four for A, four for B), pulses mmu_start for START_CYCLES cycles,
// waits for mmu_done with a timeout, then streams the four result bytes
// out low byte first. A timeout raises a one-cycle err and drops the run.
module mmu_driver
    import mmu_driver_pkg::*;
#(
    parameter int START_CYCLES = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        mmu_start,
    output logic [31:0] mmu_A_flat,
    output logic [31:0] mmu_B_flat,
    input  logic [31:0] mmu_C_flat,
    input  logic        mmu_done,
    output logic        err
);

    // One counter serves both the start-pulse length and the WAIT timeout.
    localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES);
    localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       IN_LAST    = 3'(BYTES_IN - 1);
    localparam logic [1:0]       OUT_LAST   = 2'(BYTES_OUT - 1);

    drv_state_t       r_state;
    logic [2:0]       r_in_idx;
    logic [1:0]       r_out_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_result;
    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_err;

    // Operand acceptance is a pure function of state so upstream sees no
    // dependence on its own valid.
    assign in_ready = (r_state == ST_LOAD);

    // Main sequencer: load operands, drive start, wait for result, drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_in_idx    <= '0;
            r_out_idx   <= '0;
            r_cnt       <= '0;
            r_start     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (r_in_idx[2] == 1'b0) begin
                            r_a[{r_in_idx[1:0], 3'b000} +: OPW] <= in_data;
                        end else begin
                            r_b[{r_in_idx[1:0], 3'b000} +: OPW] <= in_data;
                        end
                        if (r_in_idx == IN_LAST) begin
                            // Start goes high on the same edge as the last byte.
                            r_in_idx <= '0;
                            r_start  <= 1'b1;
                            r_cnt    <= CNT_W'(1);
                            r_state  <= ST_RUN;
                        end else begin
                            r_in_idx <= r_in_idx + 3'd1;
                        end
                    end
                end
                ST_RUN: begin
                    // r_cnt holds how many start cycles have been presented.
                    if (r_cnt == START_LAST) begin
                        r_start <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // A done arriving on the final timeout cycle still wins.
                    if (mmu_done) begin
                        r_result    <= mmu_C_flat;
                        r_out_data  <= word_byte(mmu_C_flat, 2'd0);
                        r_out_valid <= 1'b1;
                        r_out_idx   <= '0;
                        r_cnt       <= '0;
                        r_state     <= ST_DRAIN;
                    end else if (r_cnt == TOUT_LAST) begin
                        r_err    <= 1'b1;
                        r_cnt    <= '0;
                        r_in_idx <= '0;
                        r_state  <= ST_LOAD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (r_out_idx == OUT_LAST) begin
                            r_out_valid <= 1'b0;
                            r_out_idx   <= '0;
                            r_state     <= ST_LOAD;
                        end else begin
                            r_out_idx  <= r_out_idx + 2'd1;
                            r_out_data <= word_byte(r_result, r_out_idx + 2'd1);
                        end
                    end
                end
                default: begin
                    r_state     <= ST_LOAD;
                    r_in_idx    <= '0;
                    r_cnt       <= '0;
                    r_start     <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mmu_start  = r_start;
    assign mmu_A_flat = r_a;
    assign mmu_B_flat = r_b;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign err        = r_err;

endmodule

// File: tb/tb_mmu_driver.sv
// Scoreboard bench for mmu_driver paired with the mmu model.
module tb_mmu_driver;

    localparam int START_CYCLES = 3;
    localparam int TIMEOUT      = 15;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        mmu_start;
    logic [31:0] mmu_A_flat;
    logic [31:0] mmu_B_flat;
    logic [31:0] mmu_C_flat;
    logic        w_mmu_done;
    logic        w_done_gated;
    logic        done_block;
    logic        err;

    int n_checks;
    int n_errors;
    logic [7:0] exp_q[$];

    assign w_done_gated = w_mmu_done & ~done_block;

    mmu_driver #(.START_CYCLES(START_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mmu_start(mmu_start), .mmu_A_flat(mmu_A_flat), .mmu_B_flat(mmu_B_flat),
        .mmu_C_flat(mmu_C_flat), .mmu_done(w_done_gated), .err(err)
    );

    mmu #(.START_CYCLES(START_CYCLES)) u_mmu (
        .clk(clk), .rst(rst), .start(mmu_start),
        .A_flat(mmu_A_flat), .B_flat(mmu_B_flat),
        .C_flat(mmu_C_flat), .done(w_mmu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every accepted result byte is popped and compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_byte", 64'(out_data), 64'hFFFF_FFFF);
            end else begin
                chk("out_byte", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    // One run: ops byte i in ops[8i+:8]; exp byte j in exp[8j+:8].
    task automatic do_run(input logic [63:0] ops, input logic [31:0] exp,
                          input bit rnd, input int hold, input bit tmo);
        int  errs_seen;
        int  valid_seen;
        bit  finished;
        out_ready = (hold == 0);
        for (int i = 0; i < 8; i++) begin
            if (rnd) begin
                int gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = ops[8*i +: 8];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (!tmo) begin
            for (int j = 0; j < 4; j++) exp_q.push_back(exp[8*j +: 8]);
        end
        errs_seen  = 0;
        valid_seen = 0;
        finished   = 1'b0;
        for (int k = 1; k <= 40 && !finished; k++) begin
            @(negedge clk);
            if (k <= 5) chk("mmu_start_cycle", 64'(mmu_start), 64'(k <= START_CYCLES));
            if (k <= 4) begin
                chk("mmu_A_stable", 64'(mmu_A_flat), 64'(ops[31:0]));
                chk("mmu_B_stable", 64'(mmu_B_flat), 64'(ops[63:32]));
            end
            if (tmo) begin
                if (err) errs_seen++;
                if (out_valid) valid_seen++;
                if (k == 4 + TIMEOUT) chk("err_at_timeout", 64'(err), 64'd1);
                if (k == 5 + TIMEOUT) begin
                    chk("in_ready_after_err", 64'(in_ready), 64'd1);
                    finished = 1'b1;
                end
            end else begin
                if (k <= 5) chk("out_valid_latency", 64'(out_valid), 64'(k == 5));
                if (k >= 5 && k < 5 + hold) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", 64'(out_data), 64'(exp[7:0]));
                end
                if (k > 5 && in_ready) finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                out_ready = (k + 1 >= 5 + hold);
                in_valid  = rnd & ~in_ready & 1'($urandom_range(0, 1));
                in_data   = 8'hEE;
            end
        end
        in_valid = 1'b0;
        if (!finished) chk("run_completion_bound", 64'd0, 64'd1);
        if (tmo) begin
            chk("err_pulse_count", 64'(errs_seen), 64'd1);
            chk("no_output_on_timeout", 64'(valid_seen), 64'd0);
        end else begin
            chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        end
        out_ready = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_mmu_start"}, 64'(mmu_start), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_A"}, 64'(mmu_A_flat), 64'd0);
        chk({tag, "_B"}, 64'(mmu_B_flat), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    endtask

    // Hard bound on the whole run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    localparam logic [63:0] OPS1 = 64'h0807_0605_0403_0201;
    localparam logic [31:0] EXP1 = 32'h322B_1613;      // 19,22,43,50
    localparam logic [63:0] OPS2 = 64'h0010_0010_0000_1010;
    localparam logic [31:0] EXP2 = 32'h0000_0000;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b1;
        done_block = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic run with latency checks.
        do_run(OPS1, EXP1, 1'b0, 0, 1'b0);
        // Backpressure: out_ready low for five DRAIN cycles.
        do_run(OPS1, EXP1, 1'b0, 5, 1'b0);
        // Back-to-back runs, second wraps to zero.
        do_run(OPS1, EXP1, 1'b0, 0, 1'b0);
        do_run(OPS2, EXP2, 1'b0, 0, 1'b0);
        // MMU never answers.
        done_block = 1'b1;
        do_run(OPS1, EXP1, 1'b0, 0, 1'b1);
        done_block = 1'b0;
        // Reset after a partial load of five bytes.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_state("midrun_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        do_run(OPS1, EXP1, 1'b0, 0, 1'b0);
        // Random in_valid gaps during LOAD and junk outside LOAD.
        do_run(OPS1, EXP1, 1'b1, 0, 1'b0);
        do_run(OPS2, EXP2, 1'b1, 2, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
